// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the I2C bus arbiter and its bus monitor.
// Contents: engine command encodings, arbiter state encodings, requester limit.
// Ports: none (package).
package i2c_arb_pkg;

  // Largest supported requester count; NREQ must stay within 2..NREQ_MAX.
  localparam int NREQ_MAX = 4;

  typedef enum logic [2:0] {
    CMD_START     = 3'd0,
    CMD_WRITE     = 3'd1,
    CMD_READ_ACK  = 3'd2,
    CMD_READ_NACK = 3'd3,
    CMD_STOP      = 3'd4
  } i2c_cmd_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FREE = 2'd1,
    GRANT     = 2'd2,
    RELEASE   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Purpose: watches the shared SCL/SDA lines for START/STOP and qualifies a free bus.
// Latency: one clk after the clk_en sample that shows the START/STOP/free condition.
// Backpressure: none; a passive observer sampled only on i_clk_en.
// Ports: clk/rst; i_clk_en sample tick; i_scl/i_sda synchronized bus levels;
//        o_bus_busy between START and STOP; o_bus_free after FREE_TICKS idle-high ticks.
module i2c_bus_monitor #(
  parameter int FREE_TICKS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clk_en,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_bus_busy,
  output logic o_bus_free
);

  localparam int CW = $clog2(FREE_TICKS + 1);

  logic          r_sda_d;
  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic          w_start;
  logic          w_stop;

  // SDA edges only count as conditions while SCL is high.
  assign w_start = i_clk_en && i_scl && r_sda_d && !i_sda;
  assign w_stop  = i_clk_en && i_scl && !r_sda_d && i_sda;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sda_d <= 1'b1;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else if (i_clk_en) begin
      r_sda_d <= i_sda;
      if (w_start) begin
        r_busy <= 1'b1;
      end else if (w_stop) begin
        r_busy <= 1'b0;
      end
      // The tick carrying the STOP still sees busy, so qualification starts after it.
      if (!r_busy && i_scl && i_sda) begin
        if (r_cnt != CW'(FREE_TICKS)) begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_bus_busy = r_busy;
  assign o_bus_free = !r_busy && (r_cnt == CW'(FREE_TICKS));

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Purpose: round-robin sharing of one byte-level I2C master engine, whole START..STOP transactions.
// Latency: grant 2 clk after req when the bus is already free; command/response mux is combinational.
// Backpressure: granted rq_cmd_ready follows eng_cmd_ready, all others held at 0.
// Ports: clk/rst, clk_en + scl_i/sda_i bus sampling, req/gnt, per-requester command in /
//        response out, shared engine command out / response in, bus_busy.
// Optional: define I2C_ARB_TIMEOUT_EN for a grant watchdog and the timeout_o port.
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ          = 2,
  parameter int FREE_TICKS    = 8,
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              scl_i,
  input  logic              sda_i,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  input  logic [NREQ-1:0]   rq_cmd_valid,
  input  logic [3*NREQ-1:0] rq_cmd,
  input  logic [8*NREQ-1:0] rq_cmd_data,
  output logic [NREQ-1:0]   rq_cmd_ready,
  output logic [NREQ-1:0]   rq_rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              rsp_nack,
  output logic              eng_cmd_valid,
  output logic [2:0]        eng_cmd,
  output logic [7:0]        eng_cmd_data,
  input  logic              eng_cmd_ready,
  input  logic              eng_rsp_valid,
  input  logic [7:0]        eng_rsp_data,
  input  logic              eng_rsp_nack,
`ifdef I2C_ARB_TIMEOUT_EN
  output logic [NREQ-1:0]   timeout_o,
`endif
  output logic              bus_busy
);

  localparam int IW = $clog2(NREQ);

  arb_state_e      r_state;
  arb_state_e      w_state_nxt;
  logic [NREQ-1:0] r_gnt;
  logic [IW-1:0]   r_win;
  logic [IW-1:0]   r_ptr;
  logic            r_inject;
  logic [IW-1:0]   w_pick;
  logic            w_bus_free;
  logic            w_inj;
  logic            w_to;
  logic            w_hs;

  // First asserted request at or after the pointer, wrapping modulo NREQ.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] w;
    int            idx;
    w = p;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % NREQ;
      if (r[idx]) w = IW'(idx);
    end
    return w;
  endfunction

  i2c_bus_monitor #(.FREE_TICKS(FREE_TICKS)) u_mon (
    .clk        (clk),
    .rst        (rst),
    .i_clk_en   (clk_en),
    .i_scl      (scl_i),
    .i_sda      (sda_i),
    .o_bus_busy (bus_busy),
    .o_bus_free (w_bus_free)
  );

  assign w_pick   = rr_pick(req, r_ptr);
  assign gnt      = r_gnt;
  assign rsp_data = eng_rsp_data;
  assign rsp_nack = eng_rsp_nack;
  assign w_hs     = eng_cmd_valid && eng_cmd_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_inj         = 1'b0;
    eng_cmd_valid = 1'b0;
    eng_cmd       = rq_cmd[3*int'(r_win) +: 3];
    eng_cmd_data  = rq_cmd_data[8*int'(r_win) +: 8];
    rq_cmd_ready  = '0;
    rq_rsp_valid  = '0;
    case (r_state)
      IDLE: begin
        if (|req) w_state_nxt = WAIT_FREE;
      end
      WAIT_FREE: begin
        if (!(|req))         w_state_nxt = IDLE;
        else if (w_bus_free) w_state_nxt = GRANT;
      end
      GRANT: begin
        rq_rsp_valid = r_gnt & {NREQ{eng_rsp_valid}};
        // Once started, the injected STOP is held until accepted even if req returns.
        w_inj = r_inject || !req[r_win] || w_to;
        if (w_inj) begin
          eng_cmd_valid = 1'b1;
          eng_cmd       = CMD_STOP;
          if (eng_cmd_ready) w_state_nxt = RELEASE;
        end else begin
          eng_cmd_valid = rq_cmd_valid[r_win];
          rq_cmd_ready  = r_gnt & {NREQ{eng_cmd_ready}};
          if (eng_cmd_valid && eng_cmd_ready && (eng_cmd == CMD_STOP)) w_state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        // The STOP response still belongs to the granted requester.
        rq_rsp_valid = r_gnt & {NREQ{eng_rsp_valid}};
        if (eng_rsp_valid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_win    <= '0;
      r_ptr    <= '0;
      r_inject <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_inject <= w_inj && !eng_cmd_ready;
      if ((r_state == WAIT_FREE) && (|req) && w_bus_free) begin
        r_win <= w_pick;
        r_gnt <= NREQ'(1) << w_pick;
      end
      if ((r_state == RELEASE) && eng_rsp_valid) begin
        r_gnt <= '0;
        r_ptr <= (r_win == IW'(NREQ - 1)) ? '0 : r_win + IW'(1);
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_TICKS + 1);

  logic [WD_W-1:0] r_wd;
  logic [NREQ-1:0] r_timeout;

  // Fires once per grant; afterwards r_inject keeps the STOP going.
  assign w_to = (r_state == GRANT) && clk_en && !r_inject &&
                (r_wd == WD_W'(TIMEOUT_TICKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd      <= '0;
      r_timeout <= '0;
    end else begin
      r_timeout <= w_to ? r_gnt : '0;
      if ((r_state != GRANT) || w_hs) begin
        r_wd <= '0;
      end else if (clk_en) begin
        r_wd <= r_wd + WD_W'(1);
      end
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_to = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: reset, grant latency, forwarding, round robin,
// external bus traffic, injected STOP, reset mid-grant and (with I2C_ARB_TIMEOUT_EN) the watchdog.
module tb_i2c_bus_arbiter;
  import i2c_arb_pkg::*;

  localparam int NREQ = 2;

  logic              clk;
  logic              rst;
  logic              clk_en;
  logic              scl_i;
  logic              sda_i;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rq_cmd_valid;
  logic [3*NREQ-1:0] rq_cmd;
  logic [8*NREQ-1:0] rq_cmd_data;
  logic [NREQ-1:0]   rq_cmd_ready;
  logic [NREQ-1:0]   rq_rsp_valid;
  logic [7:0]        rsp_data;
  logic              rsp_nack;
  logic              eng_cmd_valid;
  logic [2:0]        eng_cmd;
  logic [7:0]        eng_cmd_data;
  logic              eng_cmd_ready;
  logic              eng_rsp_valid;
  logic [7:0]        eng_rsp_data;
  logic              eng_rsp_nack;
  logic              bus_busy;
`ifdef I2C_ARB_TIMEOUT_EN
  logic [NREQ-1:0]   timeout_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  i2c_bus_arbiter #(.NREQ(NREQ), .FREE_TICKS(8), .TIMEOUT_TICKS(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .clk_en        (clk_en),
    .scl_i         (scl_i),
    .sda_i         (sda_i),
    .req           (req),
    .gnt           (gnt),
    .rq_cmd_valid  (rq_cmd_valid),
    .rq_cmd        (rq_cmd),
    .rq_cmd_data   (rq_cmd_data),
    .rq_cmd_ready  (rq_cmd_ready),
    .rq_rsp_valid  (rq_rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_nack      (rsp_nack),
    .eng_cmd_valid (eng_cmd_valid),
    .eng_cmd       (eng_cmd),
    .eng_cmd_data  (eng_cmd_data),
    .eng_cmd_ready (eng_cmd_ready),
    .eng_rsp_valid (eng_rsp_valid),
    .eng_rsp_data  (eng_rsp_data),
    .eng_rsp_nack  (eng_rsp_nack),
`ifdef I2C_ARB_TIMEOUT_EN
    .timeout_o     (timeout_o),
`endif
    .bus_busy      (bus_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One clk with a bus sample at the given levels; levels persist afterwards.
  task automatic tick(input logic s, input logic d);
    scl_i  = s;
    sda_i  = d;
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
  endtask

  // Requester idx presents a command that the engine accepts immediately.
  task automatic send(input int idx, input logic [2:0] c, input logic [7:0] d);
    rq_cmd_valid = '0;
    rq_cmd_valid[idx] = 1'b1;
    rq_cmd[3*idx +: 3] = c;
    rq_cmd_data[8*idx +: 8] = d;
    eng_cmd_ready = 1'b1;
    step();
    rq_cmd_valid  = '0;
    eng_cmd_ready = 1'b0;
  endtask

  task automatic rsp(input logic [7:0] d);
    eng_rsp_valid = 1'b1;
    eng_rsp_data  = d;
    step();
    eng_rsp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0; scl_i = 1'b1; sda_i = 1'b1; req = '0;
    rq_cmd_valid = '0; rq_cmd = '0; rq_cmd_data = '0;
    eng_cmd_ready = 1'b0; eng_rsp_valid = 1'b0; eng_rsp_data = '0; eng_rsp_nack = 1'b0;

    // Reset values
    step();
    check("rst_gnt", gnt, 0);
    check("rst_eng_valid", eng_cmd_valid, 0);
    check("rst_rq_ready", rq_cmd_ready, 0);
    check("rst_rq_rsp", rq_rsp_valid, 0);
    check("rst_busy", bus_busy, 0);
    rst = 1'b0;

    // Single transaction from requester 0 on a free bus
    repeat (8) tick(1'b1, 1'b1);
    req = 2'b01;
    step();
    check("lat_1clk", gnt, 0);
    step();
    check("lat_2clk", gnt, 2'b01);
    rq_cmd_valid = 2'b01; rq_cmd[2:0] = CMD_START; eng_cmd_ready = 1'b1;
    #1;
    check("fwd_start_vld", eng_cmd_valid, 1);
    check("fwd_start_cmd", eng_cmd, 0);
    check("fwd_start_rdy", rq_cmd_ready, 2'b01);
    step();
    rq_cmd_valid = '0; eng_cmd_ready = 1'b0;
    tick(1'b1, 1'b0);
    check("mon_start_busy", bus_busy, 1);
    // WRITE 0xD0 while ungranted requester 1 also offers a command
    rq_cmd_valid = 2'b11; rq_cmd = {CMD_WRITE, CMD_WRITE}; rq_cmd_data = {8'h55, 8'hD0};
    eng_cmd_ready = 1'b1;
    #1;
    check("fwd_wr_cmd", eng_cmd, 1);
    check("fwd_wr_data", eng_cmd_data, 8'hD0);
    check("ungranted_rdy", rq_cmd_ready, 2'b01);
    step();
    rq_cmd_valid = '0; eng_cmd_ready = 1'b0;
    eng_rsp_valid = 1'b1; eng_rsp_data = 8'hA5; eng_rsp_nack = 1'b1;
    #1;
    check("rsp_vld", rq_rsp_valid, 2'b01);
    check("rsp_data", rsp_data, 8'hA5);
    check("rsp_nack", rsp_nack, 1);
    step();
    eng_rsp_valid = 1'b0; eng_rsp_nack = 1'b0;
    send(0, CMD_STOP, 8'h00);
    req = 2'b00;
    check("release_hold", gnt, 2'b01);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    check("mon_stop_busy", bus_busy, 0);
    rsp(8'h00);
    check("release_done", gnt, 0);

    // Round robin with both requesting from pointer 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (8) tick(1'b1, 1'b1);
    req = 2'b11;
    step();
    step();
    check("rr_first", gnt, 2'b01);
    send(0, CMD_START, 8'h00);
    tick(1'b1, 1'b0);
    send(0, CMD_STOP, 8'h00);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    rsp(8'h00);
    repeat (7) tick(1'b1, 1'b1);
    check("requal_7", gnt, 0);
    tick(1'b1, 1'b1);
    check("requal_8", gnt, 0);
    step();
    check("rr_second", gnt, 2'b10);
    send(1, CMD_START, 8'h00);
    tick(1'b1, 1'b0);
    send(1, CMD_STOP, 8'h00);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    rsp(8'h00);
    repeat (8) tick(1'b1, 1'b1);
    step();
    check("rr_third", gnt, 2'b01);

    // Requester 0 abandons after WRITE: STOP injected
    send(0, CMD_START, 8'h00);
    tick(1'b1, 1'b0);
    send(0, CMD_WRITE, 8'h3C);
    req = 2'b10;
    #1;
    check("inj_vld", eng_cmd_valid, 1);
    check("inj_cmd", eng_cmd, 4);
    step();
    eng_cmd_ready = 1'b1;
    #1;
    check("inj_hold_vld", eng_cmd_valid, 1);
    check("inj_rq_rdy", rq_cmd_ready, 0);
    step();
    eng_cmd_ready = 1'b0;
    #1;
    check("inj_rel_vld", eng_cmd_valid, 0);
    check("inj_rel_gnt", gnt, 2'b01);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    rsp(8'h00);
    check("inj_done", gnt, 0);

    // External master starts while requester 1 waits
    repeat (4) tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    check("ext_busy", bus_busy, 1);
    repeat (6) tick(1'b0, 1'b0);
    check("ext_hold", gnt, 0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    check("ext_stop", bus_busy, 0);
    repeat (7) tick(1'b1, 1'b1);
    check("ext_requal_7", gnt, 0);
    tick(1'b1, 1'b1);
    step();
    check("ext_grant", gnt, 2'b10);

    // Reset in the middle of a grant
    rq_cmd_valid = 2'b10; rq_cmd[5:3] = CMD_START;
    #1;
    check("pre_rst_vld", eng_cmd_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_vld", eng_cmd_valid, 0);
    step();
    rst = 1'b0; rq_cmd_valid = '0; req = '0;

`ifdef I2C_ARB_TIMEOUT_EN
    // Granted requester goes silent for 16 ticks
    repeat (8) tick(1'b1, 1'b1);
    req = 2'b11;
    step();
    step();
    check("to_gnt", gnt, 2'b01);
    send(0, CMD_START, 8'h00);
    repeat (15) tick(1'b1, 1'b1);
    check("to_quiet_pulse", timeout_o, 0);
    check("to_quiet_vld", eng_cmd_valid, 0);
    tick(1'b1, 1'b1);
    check("to_inj_vld", eng_cmd_valid, 1);
    check("to_inj_cmd", eng_cmd, 4);
    check("to_pulse", timeout_o, 2'b01);
    eng_cmd_ready = 1'b1;
    step();
    eng_cmd_ready = 1'b0;
    check("to_pulse_end", timeout_o, 0);
    rsp(8'h00);
    check("to_rel", gnt, 0);
    step();
    step();
    check("to_next", gnt, 2'b10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one byte-level I2C master engine between NREQ local requesters, e.g. RTC poller and tuner configurator, on the bridged rtc/tuner bus.
- Grants whole transactions, START through STOP, in round-robin order.
- Issues a grant only when the shared bus is observed free, since other masters may also be on the bridged segment.
- Muxes the command/response streams between the granted requester and the engine.

Parameters:
- NREQ, 2, number of requesters (2..4).
- FREE_TICKS, 8, clk_en ticks of SCL=SDA=1 after STOP before the bus counts as free.
- TIMEOUT_TICKS, 4096, clk_en ticks without a command handshake before a grant is revoked (used only with the optional feature).

Ports:
- clk  in  1  system clock (24 MHz)
- rst  in  1  asynchronous, active-high reset
- clk_en  in  1  bus-sample tick, one clk wide
- scl_i  in  1  synchronized shared SCL level
- sda_i  in  1  synchronized shared SDA level
- req  in  NREQ  per-requester transaction request, level
- gnt  out  NREQ  one-hot grant
- rq_cmd_valid  in  NREQ  per-requester command valid
- rq_cmd  in  3*NREQ  command per requester: 0 START, 1 WRITE, 2 READ_ACK, 3 READ_NACK, 4 STOP
- rq_cmd_data  in  8*NREQ  write byte per requester
- rq_cmd_ready  out  NREQ  per-requester command ready
- rq_rsp_valid  out  NREQ  per-requester response valid
- rsp_data  out  8  read byte, shared
- rsp_nack  out  1  ACK bit sampled, shared
- eng_cmd_valid  out  1  engine command valid
- eng_cmd  out  3  engine command
- eng_cmd_data  out  8  engine write byte
- eng_cmd_ready  in  1  engine command ready
- eng_rsp_valid  in  1  engine response valid
- eng_rsp_data  in  8  engine read byte
- eng_rsp_nack  in  1  engine ACK bit
- bus_busy  out  1  bus-activity flag

Behaviour:
- Reset values: gnt=0, eng_cmd_valid=0, rq_cmd_ready=0, rq_rsp_valid=0, bus_busy=0, free counter=0, round-robin pointer=0, state=IDLE.
- Bus monitor samples only on clk_en:
  - START is SDA falling while SCL=1; it sets bus_busy.
  - STOP is SDA rising while SCL=1; it clears bus_busy.
  - Free counter counts clk_en ticks with !bus_busy && scl_i && sda_i; it saturates at FREE_TICKS and resets to 0 on any low level.
- bus_free means !bus_busy && counter==FREE_TICKS.
- State IDLE: if any req, go to WAIT_FREE.
- State WAIT_FREE:
  - When bus_free, choose the winner: first asserted req at or after the pointer, wrapping modulo NREQ.
  - Register gnt one-hot on the next clk and go to GRANT.
  - If all req drop before bus_free, return to IDLE.
- State GRANT, combinational mux:
  - eng_cmd_valid/eng_cmd/eng_cmd_data come from the granted requester.
  - Only the granted rq_cmd_ready follows eng_cmd_ready; the others are 0.
  - rq_rsp_valid[g] = eng_rsp_valid; rsp_data and rsp_nack pass through.
- Leaving GRANT:
  - When a STOP command handshakes, go to RELEASE.
  - If the granted req drops without STOP, the arbiter injects a STOP itself: eng_cmd=4, eng_cmd_valid=1 until ready, then RELEASE.
- State RELEASE:
  - Wait for the STOP response (eng_rsp_valid), then gnt=0.
  - Pointer becomes winner+1 mod NREQ; go to IDLE.
  - Grant latency from a bus_free requester: 2 clk. A requester may not be re-granted before the bus monitor re-qualifies FREE_TICKS.
- Simultaneous events:
  - A new req during GRANT is queued; it has no effect until RELEASE.
  - req and STOP handshake in the same cycle: STOP wins.
- External START seen during WAIT_FREE: bus_free falls and the grant is withheld. No check is made in GRANT; the engine owns arbitration-loss.
- Reset mid-transaction: all outputs return to reset values immediately. The engine is expected to be reset by the same rst.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- With the macro:
  - A watchdog counts clk_en ticks in GRANT; it clears on every command handshake.
  - On reaching TIMEOUT_TICKS, the arbiter stops forwarding requester commands (rq_cmd_ready=0), injects STOP, goes to RELEASE, and pulses timeout_o[g] for one clk.
  - This adds port timeout_o, out, NREQ.
- Without the macro: no counter, no timeout_o port; a grant is held indefinitely.

Decomposition:
- Shared package i2c_arb_pkg:
  - command encodings CMD_START/WRITE/READ_ACK/READ_NACK/STOP;
  - state encodings IDLE/WAIT_FREE/GRANT/RELEASE;
  - the NREQ limit.
- Sub-module i2c_bus_monitor: START/STOP detect, bus_busy, free counter; outputs bus_busy and bus_free. It is reusable by the engine.

Test Plan:
- Idle bus (SCL=SDA=1 for 8 ticks), req=01 → gnt=01 two clk after req; START/WRITE 0xD0/STOP forwarded; gnt=00 after STOP response.
- req=11 at once, pointer 0 → grant order 01 then 10, then 01 again when both are held.
- External START (SDA falls with SCL=1) while req=10 pending → gnt stays 00 until STOP plus 8 free ticks, then gnt=10.
- Granted requester drops req after WRITE without STOP → eng_cmd=4 injected, gnt clears after the response.
- Ungranted requester asserts rq_cmd_valid → its rq_cmd_ready=0 and eng_cmd is unaffected.
- With I2C_ARB_TIMEOUT_EN and TIMEOUT_TICKS=16: granted requester idle for 16 ticks → STOP injected, timeout_o pulse on that index, next requester granted. Asserting rst mid-GRANT → gnt=0 and eng_cmd_valid=0 in the same cycle.
